// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and defaults.
// Used by the memory stage and its storage.
package mips_pkg;

  localparam int DEPTH_DEF    = 256;
  localparam int MEM_WAIT_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        regwrite;
    logic        isload;
    logic        misalign;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic [31:0] aluresult;
    logic [31:0] readdata;
  } mem_wb_t;

  function automatic logic is_misaligned(
    input logic [31:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM.
// Synchronous write, combinational read.
module data_memory
  import mips_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // write the addressed word when enabled
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage with wait-stated data RAM.
// Stalls upstream until the access completes.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        memwriteM,
  input  logic        isloadM,
  input  logic        memreadM,
  input  logic [4:0]  rdM,
  input  logic [31:0] pcplus4M,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic        stallM,
  output logic        regwriteW,
  output logic        isloadW,
  output logic [4:0]  rdW,
  output logic [31:0] pcplus4W,
  output logic [31:0] aluresultW,
  output logic [31:0] readdataW,
  output logic        misalignW
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] WINIT =
    (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  localparam logic HAS_WAIT = (MEM_WAIT != 0);

  mem_state_t    r_state;
  mem_state_t    w_state_nx;
  logic [3:0]    r_wcnt;
  logic [3:0]    w_wcnt_nx;
  logic          w_access;
  logic          w_stall;
  logic          w_done;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  mem_wb_t       r_wb;

  assign w_access = memreadM | memwriteM;
  assign w_idx    = aluresultM[AW+1:2];
  assign w_we     = w_done & memwriteM;

  // next state, wait count and stall/complete
  always_comb begin
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_access && HAS_WAIT) begin
          w_stall    = 1'b1;
          w_wcnt_nx  = WINIT;
          w_state_nx = WAIT;
        end else begin
          w_done = 1'b1;
        end
      end
      WAIT: begin
        if (r_wcnt != 4'd0) begin
          w_stall   = 1'b1;
          w_wcnt_nx = r_wcnt - 4'd1;
        end else begin
          w_done     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (rst) begin
      w_stall = 1'b0;
      w_done  = 1'b0;
    end
  end

  assign stallM = w_stall;

  // state and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
    end
  end

  data_memory #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (w_idx),
    .i_wdata(writedataM),
    .o_rdata(w_rdata)
  );

  // MEM/WB register: bubble while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb <= '0;
    end else if (w_stall) begin
      r_wb.regwrite <= 1'b0;
      r_wb.isload   <= 1'b0;
      r_wb.misalign <= 1'b0;
      r_wb.rd       <= 5'd0;
    end else begin
      r_wb.regwrite  <= regwriteM;
      r_wb.isload    <= isloadM;
      r_wb.misalign  <= w_access &
                        is_misaligned(aluresultM);
      r_wb.rd        <= rdM;
      r_wb.pcplus4   <= pcplus4M;
      r_wb.aluresult <= aluresultM;
      r_wb.readdata  <= memreadM ? w_rdata : 32'd0;
    end
  end

  assign regwriteW  = r_wb.regwrite;
  assign isloadW    = r_wb.isload;
  assign misalignW  = r_wb.misalign;
  assign rdW        = r_wb.rd;
  assign pcplus4W   = r_wb.pcplus4;
  assign aluresultW = r_wb.aluresult;
  assign readdataW  = r_wb.readdata;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage.
// Two instances: MEM_WAIT=2 and MEM_WAIT=0.
module tb_memory_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        regwriteM, memwriteM;
  logic        isloadM, memreadM;
  logic [4:0]  rdM;
  logic [31:0] pcplus4M, aluresultM, writedataM;
  logic        stallM, regwriteW, isloadW, misalignW;
  logic [4:0]  rdW;
  logic [31:0] pcplus4W, aluresultW, readdataW;

  logic        z_regwriteM, z_memwriteM;
  logic        z_isloadM, z_memreadM;
  logic [4:0]  z_rdM;
  logic [31:0] z_pcplus4M, z_aluresultM, z_writedataM;
  logic        z_stallM, z_regwriteW, z_isloadW, z_misalignW;
  logic [4:0]  z_rdW;
  logic [31:0] z_pcplus4W, z_aluresultW, z_readdataW;

  memory_stage #(.DEPTH(256), .MEM_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memwriteM(memwriteM),
    .isloadM(isloadM), .memreadM(memreadM),
    .rdM(rdM), .pcplus4M(pcplus4M),
    .aluresultM(aluresultM), .writedataM(writedataM),
    .stallM(stallM), .regwriteW(regwriteW),
    .isloadW(isloadW), .rdW(rdW),
    .pcplus4W(pcplus4W), .aluresultW(aluresultW),
    .readdataW(readdataW), .misalignW(misalignW)
  );

  memory_stage #(.DEPTH(256), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .regwriteM(z_regwriteM), .memwriteM(z_memwriteM),
    .isloadM(z_isloadM), .memreadM(z_memreadM),
    .rdM(z_rdM), .pcplus4M(z_pcplus4M),
    .aluresultM(z_aluresultM), .writedataM(z_writedataM),
    .stallM(z_stallM), .regwriteW(z_regwriteW),
    .isloadW(z_isloadW), .rdW(z_rdW),
    .pcplus4W(z_pcplus4W), .aluresultW(z_aluresultW),
    .readdataW(z_readdataW), .misalignW(z_misalignW)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rw, we, re, il;
    logic [4:0]  rd;
    logic [31:0] pc, alu, wd, e_rdata;
    logic        e_mis;
  } vec_t;

  vec_t tv[9];

  // one access on the MEM_WAIT=2 instance; entered at posedge+1
  task automatic do_op(input logic we, input logic re,
                       input logic il, input logic rw,
                       input logic [4:0] rd,
                       input logic [31:0] pc,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       output int ns);
    bit done;
    regwriteM  = rw;
    memwriteM  = we;
    memreadM   = re;
    isloadM    = il;
    rdM        = rd;
    pcplus4M   = pc;
    aluresultM = addr;
    writedataM = wd;
    ns   = 0;
    done = 1'b0;
    for (int g = 0; g < 20 && !done; g++) begin
      #1;
      if (stallM) begin
        ns++;
        @(posedge clk); #1;
        chk("bubble_regwrite", 32'(regwriteW), 0);
        chk("bubble_rd", 32'(rdW), 0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) chk("stall_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ns;
    tv[0] = '{1,0,0,0,5'd3,32'h04,32'h1234,0,0,0};
    tv[1] = '{0,1,0,0,5'd0,32'h08,32'h40,
              32'hCAFEF00D,0,0};
    tv[2] = '{1,0,1,1,5'd7,32'h0C,32'h40,0,
              32'hCAFEF00D,0};
    tv[3] = '{0,1,0,0,5'd0,32'h10,32'h41,
              32'h01020304,0,1};
    tv[4] = '{1,1,1,1,5'd9,32'h14,32'h40,
              32'hAAAA5555,32'h01020304,0};
    tv[5] = '{1,0,1,1,5'd10,32'h18,32'h40,0,
              32'hAAAA5555,0};
    tv[6] = '{1,0,1,1,5'd11,32'h1C,32'h440,0,
              32'hAAAA5555,0};
    tv[7] = '{1,0,0,0,5'd12,32'h20,32'h3,0,0,0};
    tv[8] = '{1,0,1,1,5'd13,32'h24,32'h42,0,
              32'hAAAA5555,1};

    rst = 1'b1;
    regwriteM = 1; memwriteM = 1; memreadM = 1;
    isloadM = 1; rdM = 5'd4; pcplus4M = 32'h8;
    aluresultM = 32'h10; writedataM = 32'h1;
    z_regwriteM = 1; z_memwriteM = 0; z_memreadM = 1;
    z_isloadM = 1; z_rdM = 5'd4; z_pcplus4M = 32'h8;
    z_aluresultM = 32'h3; z_writedataM = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stallM), 0);
    chk("rst_regwrite", 32'(regwriteW), 0);
    chk("rst_isload", 32'(isloadW), 0);
    chk("rst_rd", 32'(rdW), 0);
    chk("rst_pc", pcplus4W, 0);
    chk("rst_alu", aluresultW, 0);
    chk("rst_rdata", readdataW, 0);
    chk("rst_mis", 32'(misalignW), 0);
    chk("rst_z_alu", z_aluresultW, 0);
    memwriteM = 0; memreadM = 0;
    isloadM = 0; regwriteM = 0;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      z_regwriteM  = tv[i].rw;
      z_memwriteM  = tv[i].we;
      z_memreadM   = tv[i].re;
      z_isloadM    = tv[i].il;
      z_rdM        = tv[i].rd;
      z_pcplus4M   = tv[i].pc;
      z_aluresultM = tv[i].alu;
      z_writedataM = tv[i].wd;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(z_stallM), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rdata", i),
          z_readdataW, tv[i].e_rdata);
      chk($sformatf("v%0d_mis", i),
          32'(z_misalignW), 32'(tv[i].e_mis));
      chk($sformatf("v%0d_regw", i),
          32'(z_regwriteW), 32'(tv[i].rw));
      chk($sformatf("v%0d_isl", i),
          32'(z_isloadW), 32'(tv[i].il));
      chk($sformatf("v%0d_rd", i),
          32'(z_rdW), 32'(tv[i].rd));
      chk($sformatf("v%0d_alu", i),
          z_aluresultW, tv[i].alu);
      chk($sformatf("v%0d_pc", i),
          z_pcplus4W, tv[i].pc);
    end
    z_memwriteM = 0; z_memreadM = 0;

    do_op(1, 0, 0, 0, 5'd0, 32'h4, 32'h10,
          32'h11111111, ns);
    chk("prestore_ns", ns, 2);

    regwriteM = 0; memwriteM = 1; memreadM = 0;
    isloadM = 0; rdM = 5'd0; pcplus4M = 32'h8;
    aluresultM = 32'h10; writedataM = 32'hDEADBEEF;
    #1;
    chk("st_stall1", 32'(stallM), 1);
    chk("st_mem1", dut.u_mem.r_mem[4], 32'h11111111);
    @(posedge clk); #1;
    chk("st_stall2", 32'(stallM), 1);
    chk("st_regw2", 32'(regwriteW), 0);
    chk("st_mem2", dut.u_mem.r_mem[4], 32'h11111111);
    @(posedge clk); #1;
    chk("st_stall3", 32'(stallM), 0);
    chk("st_mem3", dut.u_mem.r_mem[4], 32'h11111111);
    @(posedge clk); #1;
    chk("st_mem_done", dut.u_mem.r_mem[4], 32'hDEADBEEF);
    chk("st_regw_done", 32'(regwriteW), 0);
    chk("st_rdata_done", readdataW, 0);

    do_op(0, 1, 1, 1, 5'd5, 32'hC, 32'h10, 0, ns);
    chk("ld_ns", ns, 2);
    chk("ld_rdata", readdataW, 32'hDEADBEEF);
    chk("ld_isload", 32'(isloadW), 1);
    chk("ld_rd", 32'(rdW), 5);
    chk("ld_regw", 32'(regwriteW), 1);

    do_op(0, 0, 0, 1, 5'd2, 32'h44, 32'h1234, 0, ns);
    chk("alu_ns", ns, 0);
    chk("alu_res", aluresultW, 32'h1234);
    chk("alu_pc", pcplus4W, 32'h44);
    chk("alu_rdata", readdataW, 0);
    chk("alu_rd", 32'(rdW), 2);

    do_op(1, 0, 0, 0, 5'd0, 32'h48, 32'h403,
          32'h5A5A0001, ns);
    chk("wrap_ns", ns, 2);
    chk("wrap_mis", 32'(misalignW), 1);
    do_op(0, 0, 0, 0, 5'd0, 32'h4C, 32'h0, 0, ns);
    chk("wrap_mis_off", 32'(misalignW), 0);
    do_op(0, 1, 1, 1, 5'd6, 32'h50, 32'h0, 0, ns);
    chk("wrap_ld0", readdataW, 32'h5A5A0001);
    chk("wrap_ld0_mis", 32'(misalignW), 0);
    do_op(0, 1, 1, 1, 5'd6, 32'h54, 32'h10, 0, ns);
    chk("wrap_ld10", readdataW, 32'hDEADBEEF);

    do_op(1, 0, 0, 0, 5'd0, 32'h58, 32'h20,
          32'h77770000, ns);
    regwriteM = 0; memwriteM = 1; memreadM = 0;
    isloadM = 0; rdM = 5'd0; pcplus4M = 32'h5C;
    aluresultM = 32'h20; writedataM = 32'h88888888;
    #1;
    chk("ab_stall1", 32'(stallM), 1);
    @(posedge clk); #1;
    chk("ab_stall2", 32'(stallM), 1);
    rst = 1'b1;
    memwriteM = 0;
    #1;
    chk("ab_stall_rst", 32'(stallM), 0);
    @(posedge clk); #1;
    chk("ab_mem", dut.u_mem.r_mem[8], 32'h77770000);
    chk("ab_state", 32'(dut.r_state), 32'(IDLE));
    chk("ab_wcnt", 32'(dut.r_wcnt), 0);
    chk("ab_pc", pcplus4W, 0);
    chk("ab_alu", aluresultW, 0);
    chk("ab_rdata", readdataW, 0);
    chk("ab_rd", 32'(rdW), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ab_mem_after", dut.u_mem.r_mem[8], 32'h77770000);
    do_op(0, 1, 1, 1, 5'd8, 32'h60, 32'h20, 0, ns);
    chk("ab_ld_ns", ns, 2);
    chk("ab_ld", readdataW, 32'h77770000);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the data memory size in 32-bit words (power of two).
REQ-002 Parameter MEM_WAIT, default 2, SHALL set the wait-state cycles per memory access (0..15).
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 regwriteM, memwriteM, isloadM, memreadM  in  1 each  control bits from the EX/MEM register.
REQ-006 rdM  in  5  destination register.
REQ-007 pcplus4M  in  32  PC+4 of the instruction in MEM.
REQ-008 aluresultM  in  32  ALU result; byte address for loads and stores.
REQ-009 writedataM  in  32  store data.
REQ-010 stallM  out  1  high while the access is incomplete; upstream SHALL hold all M inputs stable while it is high.
REQ-011 regwriteW, isloadW  out  1 each  registered control bits to WB.
REQ-012 rdW  out  5; pcplus4W, aluresultW, readdataW  out  32 each  registered MEM/WB outputs.
REQ-013 misalignW  out  1  registered; high for one cycle when a completed access had aluresultM[1:0]!=0.

Function
REQ-014 An access is any cycle with memreadM or memwriteM high; all other cycles are pass-through and complete in one cycle.
REQ-015 FSM states: IDLE, WAIT; a 4-bit wait counter wcnt.
REQ-016 IDLE with an access and MEM_WAIT>0: stallM=1, wcnt<=MEM_WAIT-1, next state WAIT.
REQ-017 WAIT: stallM=(wcnt!=0); wcnt decrements while nonzero; when wcnt==0 the access completes and the next state is IDLE.
REQ-018 stallM SHALL be high for exactly MEM_WAIT consecutive cycles per access; completion occurs in the following cycle.
REQ-019 MEM_WAIT=0: the access SHALL complete in the cycle presented, with stallM never asserted.
REQ-020 stallM SHALL be combinational from the state, wcnt and the M control inputs.
REQ-021 Word index = aluresultM[log2(DEPTH)+1:2]; higher bits ignored (address wraps modulo DEPTH words); bits [1:0] ignored for the access itself.
REQ-022 Store: the memory word SHALL be written with writedataM on the completion-cycle clock edge only, exactly once per access.
REQ-023 Load: readdataW SHALL capture the addressed word on the completion edge; readdataW SHALL be 0 after any non-load completion.
REQ-024 memreadM and memwriteM both high: treated as one access; the store is performed and readdataW returns the pre-write word.
REQ-025 On each completion or pass-through edge, the W outputs SHALL capture the corresponding M inputs; latency M->W is 1 cycle after completion.
REQ-026 While stallM is high, the MEM/WB register SHALL load a bubble: regwriteW=0, isloadW=0, misalignW=0, rdW=0; the other W outputs are held.
REQ-027 Back-to-back accesses: a new access presented in the cycle after completion SHALL start a fresh stall sequence from IDLE.

Reset
REQ-028 rst high SHALL force state IDLE, wcnt=0 and all W outputs to 0 on the next edge; stallM SHALL be 0 while rst is high.
REQ-029 Reset during WAIT SHALL abort the access; no memory write occurs.
REQ-030 Memory contents SHALL NOT be reset.

Structure
REQ-031 The FSM state type and the default DEPTH/MEM_WAIT constants SHALL reside in the shared package mips_pkg.
REQ-032 Storage SHALL be a sub-module data_memory with a synchronous write, a combinational read and a DEPTH parameter.

Verification
REQ-033 MEM_WAIT=2, store 0xDEADBEEF to address 0x10 -> stallM high for 2 cycles, the word is written at the completion edge, regwriteW=0 throughout.
REQ-034 Load from 0x10 with rdM=5 -> stallM for 2 cycles, then readdataW=0xDEADBEEF, isloadW=1, rdW=5.
REQ-035 ALU op with no access, aluresultM=0x1234 -> no stall, aluresultW=0x1234 on the next cycle.
REQ-036 Store to 0x403 with DEPTH=256 -> word index 0 is written (wrap), misalignW pulses for 1 cycle.
REQ-037 rst asserted during the second stall cycle of a store -> the target word is unchanged, all outputs are 0, state is IDLE.
REQ-038 MEM_WAIT=0, load immediately after store to the same address -> no stall; the load returns the stored value.
